alu_issue_queue: RTL and testbench

Buffers decoded ALU operations between decode and the ALU core and issues them in order over a valid/ready handshake. Each entry carries a `p_alu::s_control` plus operands; an entry may request that either operand be replaced by the most recent ALU result, in which case issue waits until all earlier in-flight operations have returned. Sits directly upstream of the ALU core, and receives the ALU's result back for forwarding.

---
 rtl/alu_issue_queue.sv | 111 +++++++++++
 tb/tb_alu_issue_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: in-order ALU issue FIFO with in-flight tracking and last-result forwarding
package p_alu;
    typedef struct packed {
        logic [3:0] op;
        logic       sub;
        logic       word;
    } s_control;
endpackage

module alu_issue_queue #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 4,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  p_alu::s_control        in_ctrl,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic                   in_fwd_a,
    input  logic                   in_fwd_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output p_alu::s_control        out_ctrl,
    output logic [WIDTH-1:0]       out_a,
    output logic [WIDTH-1:0]       out_b,
    input  logic                   res_valid,
    input  logic [WIDTH-1:0]       res_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PMAX = PW'(MAX_INFLIGHT);

    typedef struct packed {
        p_alu::s_control  ctrl;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             fwd_a;
        logic             fwd_b;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    pending_q, pending_d;
    logic [WIDTH-1:0] last_res_q, last_res_d;
    logic             last_valid_q, last_valid_d, err_q, err_d;
    logic             push, pop, res_ok, head_fwd;
    entry_t           head;

    // A forwarding head may only issue once every older op has returned its result.
    always_comb begin
        head      = mem_q[rd_ptr_q];
        head_fwd  = head.fwd_a || head.fwd_b;
        in_ready  = count_q != FULL;
        out_valid = count_q != '0 && pending_q != PMAX &&
                    (!head_fwd || (pending_q == '0 && last_valid_q));
        out_ctrl  = head.ctrl;
        out_a     = head.fwd_a ? last_res_q : head.a;
        out_b     = head.fwd_b ? last_res_q : head.b;
        count     = count_q;
        err       = err_q;
        push      = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready;
        res_ok    = res_valid && pending_q != '0;
    end

    // Flush only empties storage; in-flight accounting continues since issued ops still return.
    always_comb begin
        mem_d = mem_q;
        if (push)
            mem_d[wr_ptr_q] = '{ctrl: in_ctrl, a: in_a, b: in_b, fwd_a: in_fwd_a, fwd_b: in_fwd_b};
        wr_ptr_d     = flush ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d     = flush ? '0 : rd_ptr_q + AW'(pop);
        count_d      = flush ? '0 : count_q + CW'(push) - CW'(pop);
        pending_d    = pending_q + PW'(pop) - PW'(res_ok);
        last_res_d   = res_ok ? res_data : last_res_q;
        last_valid_d = last_valid_q || res_ok;
        err_d        = err_q || (res_valid && pending_q == '0 && !pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pending_q    <= '0;
            last_res_q   <= '0;
            last_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pending_q    <= pending_d;
            last_res_q   <= last_res_d;
            last_valid_q <= last_valid_d;
            err_q        <= err_d;
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed scoreboard bench for alu_issue_queue
module tb_alu_issue_queue;
    logic            clk = 1'b0;
    logic            rst_n, flush, in_valid, in_ready, in_fwd_a, in_fwd_b;
    logic            out_valid, out_ready, res_valid, err;
    p_alu::s_control in_ctrl, out_ctrl;
    logic [31:0]     in_a, in_b, out_a, out_b, res_data;
    logic [2:0]      count;

    typedef struct {
        p_alu::s_control ctrl;
        logic [31:0]     a;
        logic [31:0]     b;
    } exp_t;

    exp_t sb [$];
    int   vectors = 0;
    int   miscompares = 0;
    logic ov_s;

    alu_issue_queue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_a(in_a), .in_b(in_b), .in_fwd_a(in_fwd_a), .in_fwd_b(in_fwd_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_a(out_a), .out_b(out_b),
        .res_valid(res_valid), .res_data(res_data),
        .count(count), .err(err)
    );

    always #5 clk = ~clk;

    function automatic p_alu::s_control ctl(input logic [3:0] op);
        ctl = '{op: op, sub: op[0], word: op[1]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // Sample at the falling edge, score any issue, then advance past the rising edge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        ov_s = out_valid;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL sb_underflow: observed issue, expected none");
            end else begin
                e = sb.pop_front();
                chk("out_ctrl", out_ctrl, e.ctrl);
                chk("out_a", out_a, e.a);
                chk("out_b", out_b, e.b);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic fa, input logic fb, input logic [31:0] ea, input logic [31:0] eb);
        in_valid = 1'b1;
        in_ctrl  = ctl(op);
        in_a     = a;
        in_b     = b;
        in_fwd_a = fa;
        in_fwd_b = fb;
        sb.push_back('{ctrl: ctl(op), a: ea, b: eb});
        cyc();
        in_valid = 1'b0;
        in_fwd_a = 1'b0;
        in_fwd_b = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_fwd_a = 1'b0; in_fwd_b = 1'b0;
        in_ctrl = ctl(4'h0); in_a = '0; in_b = '0;
        out_ready = 1'b0; res_valid = 1'b0; res_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        cyc();

        // Fill to DEPTH with the ALU stalled, then drain in order.
        for (int i = 1; i <= 4; i++)
            enq(4'(i), 32'(i), 32'(16 + i), 1'b0, 1'b0, 32'(i), 32'(16 + i));
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        cyc();
        chk("stall_out_a", out_a, 1);
        out_ready = 1'b1;
        cyc();
        chk("drain_ov0", ov_s, 1);
        chk("pop_in_ready", in_ready, 1);
        res_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            res_data = 32'h100 + 32'(i);
            cyc();
            chk("drain_ov", ov_s, 1);
        end
        res_data = 32'h103;
        cyc();
        chk("drained_ov", ov_s, 0);
        chk("drained_count", count, 0);
        res_valid = 1'b0;

        // Streaming at one op per cycle with a one-cycle ALU.
        for (int k = 0; k < 8; k++) begin
            in_valid = k < 6;
            if (k < 6) begin
                in_ctrl = ctl(k[3:0]);
                in_a    = 32'h200 + 32'(k);
                in_b    = ~in_a;
                sb.push_back('{ctrl: in_ctrl, a: in_a, b: in_b});
            end
            res_valid = k >= 2;
            res_data  = 32'h280 + 32'(k);
            cyc();
            chk("stream_ov", ov_s, k >= 1 && k <= 6);
        end
        in_valid = 1'b0;
        res_valid = 1'b0;
        chk("stream_err", err, 0);
        chk("stream_count", count, 0);

        // Forwarded operand waits for the older op's result.
        enq(4'h5, 32'h5, 32'h6, 1'b0, 1'b0, 32'h5, 32'h6);
        enq(4'h6, 32'hDEAD, 32'h1234, 1'b1, 1'b0, 32'h77, 32'h1234);
        chk("fwd_issue_op1", ov_s, 1);
        cyc();
        chk("fwd_hold0", ov_s, 0);
        res_valid = 1'b1;
        res_data  = 32'h77;
        cyc();
        res_valid = 1'b0;
        chk("fwd_hold1", ov_s, 0);
        cyc();
        chk("fwd_issue", ov_s, 1);
        res_valid = 1'b1;
        res_data  = 32'h55;
        cyc();
        res_valid = 1'b0;

        // In-flight limit: third op held until a result returns.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            enq(4'(8 + i), 32'h31 + 32'(i), 32'h41 + 32'(i), 1'b0, 1'b0, 32'h31 + 32'(i), 32'h41 + 32'(i));
        out_ready = 1'b1;
        cyc();
        chk("lim_ov0", ov_s, 1);
        cyc();
        chk("lim_ov1", ov_s, 1);
        res_valid = 1'b1;
        res_data  = 32'h300;
        cyc();
        chk("lim_held", ov_s, 0);
        cyc();
        chk("lim_release", ov_s, 1);
        cyc();
        chk("lim_empty", ov_s, 0);
        res_valid = 1'b0;

        // Flush beats a same-cycle enqueue.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            enq(4'hC, 32'h60 + 32'(i), 32'h70, 1'b0, 1'b0, 32'h60 + 32'(i), 32'h70);
        chk("preflush_count", count, 3);
        flush = 1'b1;
        in_valid = 1'b1;
        in_a = 32'h99;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        chk("flush_count", count, 0);
        chk("flush_ov", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        cyc();
        chk("flush_dropped", ov_s, 0);

        // Stray result: sticky err, data ignored.
        res_valid = 1'b1;
        res_data  = 32'hBAD;
        cyc();
        res_valid = 1'b0;
        chk("err_set", err, 1);
        cyc();
        chk("err_sticky", err, 1);
        enq(4'hD, 32'h0, 32'h9, 1'b1, 1'b0, 32'h300, 32'h9);
        cyc();
        chk("err_fwd_issue", ov_s, 1);
        res_valid = 1'b1;
        res_data  = 32'h400;
        cyc();
        res_valid = 1'b0;
        chk("err_still", err, 1);

        // Asynchronous reset mid-stream, then a stray return afterwards.
        out_ready = 1'b0;
        enq(4'hE, 32'h1, 32'h2, 1'b0, 1'b0, 32'h1, 32'h2);
        enq(4'hF, 32'h3, 32'h4, 1'b0, 1'b0, 32'h3, 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_err", err, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        res_valid = 1'b1;
        cyc();
        res_valid = 1'b0;
        chk("post_rst_stray_err", err, 1);

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
